// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer and its neighbours in the ALU
// control path.
//   state_t    : FSM encoding (IDLE / RUN / PAUSE)
//   CNT_W      : default count width, kept equal to Counter's width
//   PRESCALE_W : default prescale field width
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int CNT_W      = 3;
  localparam int PRESCALE_W = 4;

endpackage : countdown_timer_pkg

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer.
//   master : load, load_value, prescale, start, pause, stop, auto_reload out;
//            count, busy, done in
//   slave  : the timer side (directions reversed)
interface countdown_timer_if #(
  parameter int WIDTH      = countdown_timer_pkg::CNT_W,
  parameter int PRESCALE_W = countdown_timer_pkg::PRESCALE_W
);

  logic                  load;
  logic [WIDTH-1:0]      load_value;
  logic [PRESCALE_W-1:0] prescale;
  logic                  start;
  logic                  pause;
  logic                  stop;
  logic                  auto_reload;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic                  done;

  modport master (
    output load, load_value, prescale, start, pause, stop, auto_reload,
    input  count, busy, done
  );

  modport slave (
    input  load, load_value, prescale, start, pause, stop, auto_reload,
    output count, busy, done
  );

endinterface : countdown_timer_if

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides the clock into decrement ticks for the countdown timer.
//   clk, resetn : clock, synchronous active-low reset
//   enable      : advance the phase counter this cycle
//   clear       : force the phase counter to 0 (takes precedence over enable)
//   prescale    : tick period minus one, sampled live
//   tick        : high in the cycle where pc == prescale and enable is set
//   pc          : current phase counter
module tick_prescaler #(
  parameter int PRESCALE_W = countdown_timer_pkg::PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick,
  output logic [PRESCALE_W-1:0] pc
);

  // Equality compare: if prescale is lowered below pc mid-run, pc simply
  // wraps through 2^PRESCALE_W before matching again.
  assign tick = enable && (pc == prescale);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc <= '0;
    end else if (clear) begin
      pc <= '0;
    end else if (enable) begin
      if (tick) pc <= '0;
      else      pc <= pc + PRESCALE_W'(1);
    end
  end

endmodule : tick_prescaler

// File: rtl/countdown_timer.sv
// Loadable down-counter used as a sequencing/timeout source next to Counter.
// Counts a preset value down at a programmable rate and pulses done for one
// cycle on expiry; optionally reloads and keeps running.
//   clk, resetn : clock, synchronous active-low reset
//   bus (slave) : load/load_value/prescale/start/pause/stop/auto_reload in,
//                 count/busy/done out (all outputs registered)
module countdown_timer #(
  parameter int WIDTH      = countdown_timer_pkg::CNT_W,
  parameter int PRESCALE_W = countdown_timer_pkg::PRESCALE_W
) (
  input  logic               clk,
  input  logic               resetn,
  countdown_timer_if.slave   bus
);

  import countdown_timer_pkg::*;

  state_t                state;
  logic [WIDTH-1:0]      count_q;
  logic [WIDTH-1:0]      reload_q;
  logic                  busy_q;
  logic                  done_q;

  logic [WIDTH-1:0]      eff_count;
  logic                  start_run;
  logic                  advance;
  logic                  tick;
  // Prescaler phase; not needed by the FSM, kept visible for debug.
  logic [PRESCALE_W-1:0] pc_unused;

  // Load and start in the same cycle start from the freshly loaded value.
  assign eff_count = bus.load ? bus.load_value : count_q;
  assign start_run = (state == ST_IDLE) && bus.start && (eff_count != '0);

  // Prescaler only moves when the timer is (or is returning to) running.
  // Leaving PAUSE counts as a running cycle so pause costs exactly the
  // number of cycles pause was held.
  assign advance = ((state == ST_RUN) || (state == ST_PAUSE)) &&
                   !bus.stop && !bus.pause;

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_pre (
    .clk      (clk),
    .resetn   (resetn),
    .enable   (advance),
    .clear    (start_run),
    .prescale (bus.prescale),
    .tick     (tick),
    .pc       (pc_unused)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.load) begin
            count_q  <= bus.load_value;
            reload_q <= bus.load_value;
          end
          if (bus.start) begin
            if (eff_count != '0) begin
              state  <= ST_RUN;
              busy_q <= 1'b1;
            end else begin
              // Starting from zero expires immediately without running.
              done_q <= 1'b1;
            end
          end
        end

        ST_RUN, ST_PAUSE: begin
          if (bus.stop) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (bus.pause) begin
            state <= ST_PAUSE;
          end else begin
            state <= ST_RUN;
            if (tick) begin
              if (count_q > WIDTH'(1)) begin
                count_q <= count_q - WIDTH'(1);
              end else if (count_q == WIDTH'(1)) begin
                done_q <= 1'b1;
                if (bus.auto_reload) begin
                  count_q <= reload_q;
                end else begin
                  count_q <= '0;
                  state   <= ST_IDLE;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule : countdown_timer

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable down-counter that decrements a WIDTH-bit value at a programmable tick rate and reports expiry with a one-cycle `done` pulse. It is the counterpart to the up-counter `Counter`. `Counter` accumulates `count_up` events; this block counts a preset value down to zero and signals completion. It sits beside `Counter` in the ALU control path as the sequencing and timeout source, and can run one-shot or in auto-reload mode.

Parameters:
WIDTH, 3, bit width of count/load_value (matches Counter)
PRESCALE_W, 4, bit width of prescale input

Ports:
clk  input  1  system clock, all state changes on rising edge
resetn  input  1  synchronous active-low reset (sampled on rising clk)
load  input  1  load load_value into count and reload register (IDLE only)
load_value  input  WIDTH  value to load
prescale  input  PRESCALE_W  decrement period minus one (0 = decrement every RUN cycle)
start  input  1  begin countdown (IDLE only)
pause  input  1  level; freeze countdown while high
stop  input  1  abort countdown, return to IDLE, no done
auto_reload  input  1  level; on expiry reload from reload register and keep running
count  output  WIDTH  current count value
busy  output  1  high in RUN or PAUSE
done  output  1  one-cycle pulse on expiry

Behaviour:
- Clock and reset are decided: one clock; reset is synchronous and active-low. Ports are clk and resetn.
- Reset is resetn=0 at a clk edge. It gives state=IDLE, count=0, reload_reg=0, prescale counter pc=0, busy=0, done=0. Reset wins over every other input, including mid-run.
- All outputs are registered. done defaults to 0 every cycle unless set as described below.
- States are IDLE, RUN and PAUSE.
- IDLE behaviour:
  - load=1 gives count<=load_value and reload_reg<=load_value.
  - start=1 with effective count!=0 gives RUN, busy=1, pc<=0 on the same edge.
  - Effective count is load_value if load=1 in the same cycle, else count. Simultaneous load+start starts from the new value.
  - start=1 with effective count==0 gives done=1 next edge. The block stays in IDLE with busy=0.
  - pause, stop and auto_reload have no effect in IDLE.
- RUN behaviour, with priority stop > pause > tick:
  - stop=1 gives IDLE and busy=0. count and pc are held, and done is not asserted.
  - pause=1 gives PAUSE. pc and count do not advance on that edge.
  - Otherwise, if pc!=prescale, then pc<=pc+1.
  - Otherwise (pc==prescale) a tick occurs and pc<=0:
    - If count>1, count<=count-1.
    - If count==1 and auto_reload=0, then count<=0, state IDLE, busy<=0, done<=1.
    - If count==1 and auto_reload=1, then count<=reload_reg, state stays RUN, done<=1.
- Timing: the first decrement lands prescale+1 cycles after the RUN entry edge. A one-shot from value N with prescale P asserts done exactly N*(P+1) cycles after the start edge, with done and count==0 on the same edge.
- PAUSE behaviour:
  - stop=1 gives IDLE and busy=0.
  - pause=0 gives RUN and resumes from the held pc and count.
  - busy stays 1 throughout.
- load and start are ignored in RUN and PAUSE. prescale is sampled live, so changing it mid-run is legal. If pc>prescale after a change, the comparison is equality and pc wraps naturally at 2^PRESCALE_W.
- count never underflows; no decrement below 0 is possible.
- Widths: count arithmetic is WIDTH-bit unsigned, and pc is PRESCALE_W-bit unsigned.

Decomposition:
- Shared package/include holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2);
  - the default widths CNT_W=3 and PRESCALE_W=4, shared with Counter.
- One sub-module is natural: tick_prescaler.
  - Inputs: clk, resetn, enable, clear, prescale.
  - Outputs: tick and pc.
  - It emits tick when pc==prescale && enable, then wraps pc to 0.
  - The FSM and count datapath stay in countdown_timer.

Test Plan:
- Reset check: assert resetn=0 mid-RUN with count=5 → next edge count=0, busy=0, done=0, IDLE; start with count 0 afterwards → single done pulse, busy stays 0.
- One-shot basic: load_value=5, prescale=0, load+start same cycle → busy=1; count 5,4,3,2,1,0 on consecutive edges; done=1 exactly 5 cycles after start edge, coincident with count=0; busy=0 same edge.
- Prescaler: load 3, prescale=2, start → count decrements every 3 cycles; done at cycle 9 after start; verify pc never exceeds 2.
- Pause/stop: load 7, prescale=1, start, pause for 4 cycles after count=5 → count held at 5, busy=1; release → resumes, done at 14+4 cycles; separate run: stop at count=3 → IDLE, count=3, no done.
- Auto-reload: load 2, prescale=0, auto_reload=1, start → count 2,1,2,1,...; done pulses every 2 cycles, busy stays 1; drop auto_reload → next expiry ends in IDLE with count=0.
- Ignored inputs: during RUN apply load with load_value=6 and start → no effect on count or timing; max value load 7 (WIDTH=3) with prescale=15 → done after 7*16=112 cycles.
